// File: rtl/column_drop_engine.sv
// -----------------------------------------------------------------------------
// column_drop_engine
//
// Purpose:
//   Validates a move request (column, player) against the current red/green
//   occupancy arrays. If the column has room, the column is scanned from the
//   bottom row upward and a one-cycle placement command is issued for the
//   first empty cell. A registered per-column "full" mask and a board-full
//   flag are published every cycle, independent of the request handling.
//
// Ports:
//   clock_i          system clock, rising edge
//   reset_i          asynchronous, active-high reset
//   req_i            move request, sampled only while idle
//   selected_col_i   requested column index
//   player_i         0 = red, 1 = green, latched with req_i
//   red_array_i      red occupancy, row 0 = top, column c at bit COLS-1-c
//   green_array_i    green occupancy, same layout
//   busy_o           request in progress
//   done_o           one-cycle pulse, request finished
//   valid_o          qualified by done_o: 1 = accepted, 0 = rejected
//   place_we_o       one-cycle placement strobe (done_o && valid_o)
//   place_row_o      landing row of the last accepted move
//   place_col_o      column of the last finished request
//   place_player_o   player of the last finished request
//   col_full_o       bit c = top cell of column c occupied
//   board_full_o     every column's top cell occupied
//
// State table:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for req_i
//   ST_CHECK | column range and top-cell check on the latched request
//   ST_SCAN  | walking the column upward from the bottom, one row per cycle
// -----------------------------------------------------------------------------
module column_drop_engine #(
   parameter int ROWS  = 16,
   parameter int COLS  = 16,
   parameter int COL_W = (COLS > 1) ? $clog2(COLS) : 1,
   parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       req_i,
   input  logic [COL_W-1:0]           selected_col_i,
   input  logic                       player_i,
   input  logic [ROWS-1:0][COLS-1:0]  red_array_i,
   input  logic [ROWS-1:0][COLS-1:0]  green_array_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       valid_o,
   output logic                       place_we_o,
   output logic [ROW_W-1:0]           place_row_o,
   output logic [COL_W-1:0]           place_col_o,
   output logic                       place_player_o,
   output logic [COLS-1:0]            col_full_o,
   output logic                       board_full_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_SCAN
   } state_t;

   state_t                    state_q;
   logic [COL_W-1:0]          col_q;
   logic                      player_q;
   logic [ROW_W-1:0]          row_q;

   logic                      busy_q;
   logic                      done_q;
   logic                      valid_q;
   logic                      place_we_q;
   logic [ROW_W-1:0]          place_row_q;
   logic [COL_W-1:0]          place_col_q;
   logic                      place_player_q;
   logic [COLS-1:0]           col_full_q;
   logic                      board_full_q;

   logic [ROWS-1:0][COLS-1:0] occ;
   logic [ROWS-1:0]           col_occ;
   logic                      col_in_range;
   logic [COLS-1:0]           col_full_d;

   // A cell held by both colours simply counts as occupied.
   assign occ = red_array_i | green_array_i;

   // Extract the latched column as a vertical vector. Matching against each
   // legal index keeps an out-of-range column from ever indexing the arrays;
   // such a column leaves col_in_range low.
   always_comb begin
      col_occ      = '0;
      col_in_range = 1'b0;
      for (int c = 0; c < COLS; c++) begin
         if (col_q == COL_W'(c)) begin
            col_in_range = 1'b1;
            for (int r = 0; r < ROWS; r++) begin
               col_occ[r] = occ[r][COLS-1-c];
            end
         end
      end
   end

   always_comb begin
      col_full_d = '0;
      for (int c = 0; c < COLS; c++) begin
         col_full_d[c] = occ[0][COLS-1-c];
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q        <= ST_IDLE;
         col_q          <= '0;
         player_q       <= 1'b0;
         row_q          <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         valid_q        <= 1'b0;
         place_we_q     <= 1'b0;
         place_row_q    <= '0;
         place_col_q    <= '0;
         place_player_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
         place_we_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_i) begin
                  col_q    <= selected_col_i;
                  player_q <= player_i;
                  busy_q   <= 1'b1;
                  state_q  <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!col_in_range || col_occ[0]) begin
                  done_q         <= 1'b1;
                  busy_q         <= 1'b0;
                  place_col_q    <= col_q;
                  place_player_q <= player_q;
                  state_q        <= ST_IDLE;
               end else begin
                  row_q   <= ROW_W'(ROWS - 1);
                  state_q <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               // Row 0 was confirmed empty in ST_CHECK, so the decrement
               // below can never wrap past the top of the column.
               if (!col_occ[row_q]) begin
                  done_q         <= 1'b1;
                  valid_q        <= 1'b1;
                  place_we_q     <= 1'b1;
                  busy_q         <= 1'b0;
                  place_row_q    <= row_q;
                  place_col_q    <= col_q;
                  place_player_q <= player_q;
                  state_q        <= ST_IDLE;
               end else begin
                  row_q <= row_q - 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         col_full_q   <= '0;
         board_full_q <= 1'b0;
      end else begin
         col_full_q   <= col_full_d;
         board_full_q <= &col_full_d;
      end
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign valid_o        = valid_q;
   assign place_we_o     = place_we_q;
   assign place_row_o    = place_row_q;
   assign place_col_o    = place_col_q;
   assign place_player_o = place_player_q;
   assign col_full_o     = col_full_q;
   assign board_full_o   = board_full_q;

endmodule

// File: tb/tb_column_drop_engine.sv
// -----------------------------------------------------------------------------
// tb_column_drop_engine
//
// Purpose:
//   Drives a 16x16 engine with directed and randomized move requests and a
//   6x7 engine with directed out-of-range requests. A request-level model
//   (landing row from gravity, latency from stack height) predicts every
//   output each cycle; directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_column_drop_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b0;

   // 16x16 instance
   logic               req = 1'b0;
   logic [3:0]         sel = '0;
   logic               ply = 1'b0;
   logic [15:0][15:0]  red = '0;
   logic [15:0][15:0]  green = '0;
   logic               busy_o, done_o, valid_o, place_we_o, place_player_o, board_full_o;
   logic [3:0]         place_row_o, place_col_o;
   logic [15:0]        col_full_o;

   // 6x7 instance
   logic               req_s = 1'b0;
   logic [2:0]         sel_s = '0;
   logic               ply_s = 1'b0;
   logic [5:0][6:0]    red_s = '0;
   logic [5:0][6:0]    green_s = '0;
   logic               busy_s, done_s, valid_s, we_s, pply_s, bfull_s;
   logic [2:0]         prow_s, pcol_s;
   logic [6:0]         cfull_s;

   int n_tests = 0;
   int n_fail  = 0;

   column_drop_engine dut (
      .clock_i(clk), .reset_i(rst), .req_i(req), .selected_col_i(sel), .player_i(ply),
      .red_array_i(red), .green_array_i(green),
      .busy_o(busy_o), .done_o(done_o), .valid_o(valid_o), .place_we_o(place_we_o),
      .place_row_o(place_row_o), .place_col_o(place_col_o), .place_player_o(place_player_o),
      .col_full_o(col_full_o), .board_full_o(board_full_o)
   );

   column_drop_engine #(.ROWS(6), .COLS(7)) dut_s (
      .clock_i(clk), .reset_i(rst), .req_i(req_s), .selected_col_i(sel_s), .player_i(ply_s),
      .red_array_i(red_s), .green_array_i(green_s),
      .busy_o(busy_s), .done_o(done_s), .valid_o(valid_s), .place_we_o(we_s),
      .place_row_o(prow_s), .place_col_o(pcol_s), .place_player_o(pply_s),
      .col_full_o(cfull_s), .board_full_o(bfull_s)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Landing row for a 16x16 board, or -1 if the move must be rejected.
   function automatic int land_row(input logic [15:0][15:0] r, input logic [15:0][15:0] g,
                                   input int col);
      int b;
      if (col < 0 || col > 15) return -1;
      b = 15 - col;
      if (r[0][b] || g[0][b]) return -1;
      for (int rr = 15; rr >= 0; rr--)
         if (!(r[rr][b] || g[rr][b])) return rr;
      return -1;
   endfunction

   // ---------------- request-level reference model -----------------------
   bit        m_active = 0;
   int        m_age = 0, m_lat = 0, m_row = 0, m_col = 0;
   bit        m_ply = 0;
   bit        e_busy = 0, e_done = 0, e_valid = 0, e_we = 0, e_ply = 0, e_bfull = 0;
   int        e_row = 0, e_col = 0;
   logic [15:0] e_colfull = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 0; m_age = 0;
         e_busy = 0; e_done = 0; e_valid = 0; e_we = 0;
         e_row = 0; e_col = 0; e_ply = 0; e_colfull = '0; e_bfull = 0;
      end else begin
         e_done = 0; e_valid = 0; e_we = 0;
         for (int c = 0; c < 16; c++) e_colfull[c] = red[0][15-c] | green[0][15-c];
         e_bfull = (e_colfull == 16'hFFFF);
         if (!m_active) begin
            if (req) begin
               m_active = 1; m_age = 0; m_col = int'(sel); m_ply = ply; e_busy = 1;
            end
         end else begin
            m_age++;
            if (m_age == 1) begin
               m_row = land_row(red, green, m_col);
               m_lat = (m_row < 0) ? 1 : 2 + (15 - m_row);
            end
            if (m_age == m_lat) begin
               m_active = 0; e_busy = 0; e_done = 1;
               e_valid = (m_row >= 0); e_we = e_valid;
               if (e_valid) begin
                  e_row = m_row; e_col = m_col; e_ply = m_ply;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", busy_o, e_busy);
      chk("done", done_o, e_done);
      chk("valid", valid_o, e_valid);
      chk("place_we", place_we_o, e_we);
      chk("col_full", col_full_o, e_colfull);
      chk("board_full", board_full_o, e_bfull);
      if (e_done && e_valid) begin
         chk("place_row", place_row_o, e_row);
         chk("place_col", place_col_o, e_col);
         chk("place_player", place_player_o, e_ply);
      end
   end

   // ---------------- request drivers --------------------------------------
   task automatic do_req(input int col, input bit p, output int lat, output int row,
                         output int vld, output int pcol, output int pp);
      @(posedge clk); #2;
      req = 1'b1; sel = 4'(col); ply = p;
      @(posedge clk); #2;
      req = 1'b0;
      lat = 0; row = -1; vld = -1; pcol = -1; pp = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done_o === 1'b1) begin
            lat = k; row = int'(place_row_o); vld = int'(valid_o);
            pcol = int'(place_col_o); pp = int'(place_player_o);
            break;
         end
      end
      if (lat == 0) chk("req_timeout", 0, 1);
   endtask

   task automatic do_req_s(input int col, output int lat, output int row, output int vld);
      @(posedge clk); #2;
      req_s = 1'b1; sel_s = 3'(col);
      @(posedge clk); #2;
      req_s = 1'b0;
      lat = 0; row = -1; vld = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (done_s === 1'b1) begin
            lat = k; row = int'(prow_s); vld = int'(valid_s);
            break;
         end
      end
      if (lat == 0) chk("req_s_timeout", 0, 1);
   endtask

   task automatic random_board();
      int h, b;
      red = '0; green = '0;
      for (int c = 0; c < 16; c++) begin
         b = 15 - c;
         h = $urandom_range(0, 16);
         if ($urandom_range(0, 3) == 0) h = $urandom_range(14, 16);
         for (int k = 0; k < h; k++) begin
            case ($urandom_range(0, 4))
               0, 1:    red[15-k][b] = 1'b1;
               2, 3:    green[15-k][b] = 1'b1;
               default: begin red[15-k][b] = 1'b1; green[15-k][b] = 1'b1; end
            endcase
         end
         if (h < 15 && $urandom_range(0, 3) == 0)
            red[$urandom_range(0, 14 - h)][b] = 1'b1;
      end
   endtask

   int lat, row, vld, pcol, pp, nd, nb, c;

   initial begin
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_place_row", place_row_o, 0);
      chk("rst_col_full", col_full_o, 0);
      chk("rst_s_busy", busy_s, 0);
      #1 rst = 1'b0;

      // Empty column 3, then a 4-high alternating stack in column 3.
      chk("model_empty", land_row(red, green, 3), 15);
      do_req(3, 1'b1, lat, row, vld, pcol, pp);
      chk("empty_lat", lat, 2);
      chk("empty_row", row, 15);
      chk("empty_valid", vld, 1);
      chk("empty_col", pcol, 3);
      chk("empty_player", pp, 1);
      for (int r = 12; r <= 15; r++) begin
         if (r[0]) red[r][12] = 1'b1; else green[r][12] = 1'b1;
      end
      do_req(3, 1'b0, lat, row, vld, pcol, pp);
      chk("partial_lat", lat, 6);
      chk("partial_row", row, 11);

      // Reset in the middle of a scan of column 5 (rows 15..8 red).
      red = '0; green = '0;
      for (int r = 8; r <= 15; r++) red[r][10] = 1'b1;
      chk("model_col5", land_row(red, green, 5), 7);
      @(posedge clk); #2;
      req = 1'b1; sel = 4'd5; ply = 1'b0;
      @(posedge clk); #2;
      req = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", busy_o, 0);
      chk("midrst_done", done_o, 0);
      chk("midrst_valid", valid_o, 0);
      chk("midrst_we", place_we_o, 0);
      chk("midrst_bfull", board_full_o, 0);
      chk("midrst_row", place_row_o, 0);
      chk("midrst_col", place_col_o, 0);
      chk("midrst_player", place_player_o, 0);
      @(posedge clk); @(posedge clk); #2 rst = 1'b0;
      nd = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done_o === 1'b1 || place_we_o === 1'b1) nd++;
      end
      chk("midrst_no_done", nd, 0);
      do_req(5, 1'b0, lat, row, vld, pcol, pp);
      chk("after_rst_row", row, 7);
      chk("after_rst_lat", lat, 10);

      // Full column 0 is rejected.
      red = '0; green = '0;
      for (int r = 0; r <= 15; r++) begin
         if (r % 3 == 0) green[r][15] = 1'b1; else red[r][15] = 1'b1;
      end
      chk("model_full", land_row(red, green, 0), -1);
      do_req(0, 1'b1, lat, row, vld, pcol, pp);
      chk("full_lat", lat, 1);
      chk("full_valid", vld, 0);
      chk("full_we", place_we_o, 0);
      chk("full_colfull0", col_full_o[0], 1);

      // req held high on an empty board.
      red = '0; green = '0;
      @(posedge clk); #2;
      req = 1'b1; sel = 4'd9; ply = 1'b0;
      nd = 0; nb = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (done_o === 1'b1) begin
            nd++;
            chk("b2b_row", place_row_o, 15);
            chk("b2b_col", place_col_o, 9);
         end
         if (busy_o === 1'b1) nb++;
         if (k == 5) #1 req = 1'b0;
      end
      chk("b2b_done_count", nd, 2);
      chk("b2b_busy_cycles", nb, 4);

      // Board full, then one column opened.
      @(posedge clk); #2;
      red = '0; green = '0;
      red[0] = 16'hFF00; green[0] = 16'h00FF;
      @(posedge clk); #1;
      chk("bfull_mask", col_full_o, 16'hFFFF);
      chk("bfull_flag", board_full_o, 1);
      #1 red[0][8] = 1'b0;
      @(posedge clk); #1;
      chk("bopen_flag", board_full_o, 0);
      chk("bopen_mask", col_full_o, 16'hFF7F);
      do_req(7, 1'b1, lat, row, vld, pcol, pp);
      chk("bopen_valid", vld, 1);
      chk("bopen_row", row, 15);
      for (int k = 0; k < 3; k++) begin
         c = $urandom_range(0, 14);
         if (c >= 7) c++;
         do_req(c, 1'b0, lat, row, vld, pcol, pp);
         chk("bopen_reject", vld, 0);
         chk("bopen_reject_lat", lat, 1);
      end

      // 6x7 instance: out-of-range column, then the last legal column.
      do_req_s(7, lat, row, vld);
      chk("oor_lat", lat, 1);
      chk("oor_valid", vld, 0);
      do_req_s(6, lat, row, vld);
      chk("s_col6_lat", lat, 2);
      chk("s_col6_valid", vld, 1);
      chk("s_col6_row", row, 5);

      // Randomized boards and requests; checked by the per-cycle model.
      for (int it = 0; it < 150; it++) begin
         @(posedge clk); #2;
         random_board();
         repeat ($urandom_range(0, 2)) @(posedge clk);
         do_req($urandom_range(0, 15), 1'($urandom_range(0, 1)), lat, row, vld, pcol, pp);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
